// File: rtl/axi_wr_producer_pkg.sv
// axi_wr_producer_pkg: shared AXI constants, command struct, FSM states and AxSIZE helper
package axi_wr_producer_pkg;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  localparam int CMD_ADDR_W = 32;
  localparam int CMD_DATA_W = 32;
  typedef struct packed {
    logic [CMD_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [CMD_DATA_W-1:0] seed;
  } axi_wr_cmd_t;
  typedef enum logic [1:0] {IDLE, XFER, RESP} prod_state_t;
  function automatic logic [2:0] axi_size(input int data_w);
    return 3'($clog2(data_w / 8));
  endfunction
endpackage

// File: rtl/axi_wr_producer_if.sv
// axi_wr_producer_if: command/done port plus one AXI4 write link (AW, W, B)
//   master modport: the producer (drives cmd_ready, done_*, aw*, w*, bready)
//   slave modport : the environment (drives cmd_*, awready, wready, b*)
interface axi_wr_producer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_len;
  logic [DATA_W-1:0] cmd_seed;
  logic              done_valid;
  logic [1:0]        done_resp;
  logic              awvalid;
  logic              awready;
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic              wlast;
  logic              bvalid;
  logic              bready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  modport master (
    input  cmd_valid, cmd_addr, cmd_len, cmd_seed, awready, wready, bvalid, bid, bresp,
    output cmd_ready, done_valid, done_resp, awvalid, awid, awaddr, awlen, awsize, awburst,
           wvalid, wdata, wstrb, wlast, bready
  );
  modport slave (
    output cmd_valid, cmd_addr, cmd_len, cmd_seed, awready, wready, bvalid, bid, bresp,
    input  cmd_ready, done_valid, done_resp, awvalid, awid, awaddr, awlen, awsize, awburst,
           wvalid, wdata, wstrb, wlast, bready
  );
endinterface

// File: rtl/axi_wr_beat_gen.sv
// axi_wr_beat_gen: W-beat counter, incrementing data and registered wlast
//   i_load : latch i_len/i_seed, restart beat count
//   i_adv  : one W beat accepted
//   o_len  : latched beat count minus one
//   o_wdata: current beat data, o_wlast: current beat is the last one
module axi_wr_beat_gen #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_adv,
  input  logic [7:0]        i_len,
  input  logic [DATA_W-1:0] i_seed,
  output logic [7:0]        o_len,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_wlast
);
  logic [7:0]        r_len;
  logic [7:0]        r_cnt;
  logic [DATA_W-1:0] r_data;
  logic              r_last;
  // wlast is precomputed one beat ahead so it stays a pure register output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len  <= '0;
      r_cnt  <= '0;
      r_data <= '0;
      r_last <= 1'b0;
    end else if (i_load) begin
      r_len  <= i_len;
      r_cnt  <= '0;
      r_data <= i_seed;
      r_last <= (i_len == 8'd0);
    end else if (i_adv) begin
      r_cnt  <= r_cnt + 8'd1;
      r_data <= r_data + DATA_W'(1);
      r_last <= (r_cnt + 8'd1 == r_len);
    end
  end
  assign o_len   = r_len;
  assign o_wdata = r_data;
  assign o_wlast = r_last;
endmodule

// File: rtl/axi_wr_producer.sv
// axi_wr_producer: AXI4 write initiator, one INCR burst of generated data per command
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : command/done port and AXI write link (master modport)
//   stat_clr, stat_bursts, stat_errs : saturating burst/error counters, present
//                only when AXI_WR_PRODUCER_STATS_EN is defined
module axi_wr_producer
  import axi_wr_producer_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int TXN_ID = 0
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef AXI_WR_PRODUCER_STATS_EN
  input  logic        stat_clr,
  output logic [15:0] stat_bursts,
  output logic [15:0] stat_errs,
`endif
  axi_wr_producer_if.master bus
);
  prod_state_t       r_state;
  logic              r_cmd_ready;
  logic              r_awvalid;
  logic              r_wvalid;
  logic              r_bready;
  logic              r_done_valid;
  logic [1:0]        r_done_resp;
  logic              r_aw_done;
  logic              r_w_done;
  logic [ADDR_W-1:0] r_addr;
  logic              w_load;
  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_aw_done;
  logic              w_w_done;
  logic [7:0]        w_len;
  logic [DATA_W-1:0] w_wdata;
  logic              w_wlast;
  assign w_load    = (r_state == IDLE) && r_cmd_ready && bus.cmd_valid;
  assign w_aw_hs   = r_awvalid && bus.awready;
  assign w_w_hs    = r_wvalid && bus.wready;
  // done flags including this cycle's handshake, so RESP follows the last one directly
  assign w_aw_done = r_aw_done || w_aw_hs;
  assign w_w_done  = r_w_done || (w_w_hs && w_wlast);
  axi_wr_beat_gen #(.DATA_W(DATA_W)) u_beat (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_adv  (w_w_hs),
    .i_len  (bus.cmd_len),
    .i_seed (bus.cmd_seed),
    .o_len  (w_len),
    .o_wdata(w_wdata),
    .o_wlast(w_wlast)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cmd_ready  <= 1'b1;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_done_valid <= 1'b0;
      r_done_resp  <= AXI_RESP_OKAY;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_addr       <= '0;
    end else begin
      r_done_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          // cmd_ready re-arms one cycle after done_valid
          if (w_load) begin
            r_cmd_ready <= 1'b0;
            r_addr      <= bus.cmd_addr;
            r_awvalid   <= 1'b1;
            r_wvalid    <= 1'b1;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_state     <= XFER;
          end else r_cmd_ready <= 1'b1;
        end
        XFER: begin
          if (w_aw_hs) r_awvalid <= 1'b0;
          if (w_w_hs && w_wlast) r_wvalid <= 1'b0;
          r_aw_done <= w_aw_done;
          r_w_done  <= w_w_done;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= RESP;
          end
        end
        RESP: begin
          if (bus.bvalid) begin
            r_bready     <= 1'b0;
            r_done_valid <= 1'b1;
            r_done_resp  <= (bus.bid != ID_W'(TXN_ID)) ? AXI_RESP_SLVERR : bus.bresp;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.cmd_ready  = r_cmd_ready;
  assign bus.done_valid = r_done_valid;
  assign bus.done_resp  = r_done_resp;
  assign bus.awvalid    = r_awvalid;
  assign bus.awid       = ID_W'(TXN_ID);
  assign bus.awaddr     = r_addr;
  assign bus.awlen      = w_len;
  assign bus.awsize     = axi_size(DATA_W);
  assign bus.awburst    = AXI_BURST_INCR;
  assign bus.wvalid     = r_wvalid;
  assign bus.wdata      = w_wdata;
  assign bus.wstrb      = '1;
  assign bus.wlast      = w_wlast;
  assign bus.bready     = r_bready;
`ifdef AXI_WR_PRODUCER_STATS_EN
  logic [15:0] r_bursts;
  logic [15:0] r_errs;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bursts <= '0;
      r_errs   <= '0;
    end else if (stat_clr) begin
      r_bursts <= '0;
      r_errs   <= '0;
    end else if (r_done_valid) begin
      if (r_bursts != 16'hFFFF) r_bursts <= r_bursts + 16'd1;
      if (r_done_resp != AXI_RESP_OKAY && r_errs != 16'hFFFF) r_errs <= r_errs + 16'd1;
    end
  end
  assign stat_bursts = r_bursts;
  assign stat_errs   = r_errs;
`endif
endmodule
